btb_2way: RTL



---
 rtl/btb_2way.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/btb_2way.sv
// 2-way set-associative branch target buffer with per-set LRU and 2-bit counters.
// Optional BTB_PERF_EN macro adds lookup/mispredict performance counters.
module btb_2way #(
  parameter int         ADDR_W   = 32,
  parameter int         INDEX_W  = 3,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memory_stall,
  input  logic [ADDR_W-1:0] pc_1,
  input  logic [ADDR_W-1:0] pc_3,
  input  logic              is_branch_3,
  input  logic              taken_3,
  input  logic              prev_taken_3,
  input  logic [ADDR_W-1:0] target_3,
  output logic [ADDR_W-1:0] branch_pc,
  output logic              flush,
`ifdef BTB_PERF_EN
  output logic [31:0]       perf_lookups,
  output logic [31:0]       perf_mispredicts,
`endif
  output logic              taken
);

  localparam int SETS = 1 << INDEX_W;
  localparam int TW   = ADDR_W - 2;

  logic [1:0]       valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][2];
  logic [TW-1:0]    tgt_q   [SETS][2];
  logic [1:0]       cnt_q   [SETS][2];
  logic [SETS-1:0]  lru_q;

  logic [INDEX_W-1:0] idx_1, idx_3;
  logic [TAG_W-1:0]   tag_1, tag_3;
  logic [1:0]         match_1, match_3;
  logic               hit_1, hit_3, way_1, way_3;
  logic [TW-1:0]      stored_tgt_3;
  logic               target_wrong, dir_wrong, upd_en;
  logic [1:0]         cnt_cur, cnt_d;
  logic               victim;

  assign idx_1 = pc_1[2+INDEX_W-1:2];
  assign tag_1 = pc_1[2+INDEX_W+TAG_W-1 -: TAG_W];
  assign idx_3 = pc_3[2+INDEX_W-1:2];
  assign tag_3 = pc_3[2+INDEX_W+TAG_W-1 -: TAG_W];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      match_1[w] = valid_q[idx_1][w] && (tag_q[idx_1][w] == tag_1);
      match_3[w] = valid_q[idx_3][w] && (tag_q[idx_3][w] == tag_3);
    end
  end

  // Tags are unique within a set, so way 0 wins only when it matches.
  assign hit_1 = |match_1;
  assign way_1 = ~match_1[0];
  assign hit_3 = |match_3;
  assign way_3 = ~match_3[0];

  assign taken        = hit_1 & cnt_q[idx_1][way_1][1];
  assign stored_tgt_3 = tgt_q[idx_3][way_3];

  assign target_wrong = is_branch_3 & prev_taken_3 & taken_3 &
                        (~hit_3 | (stored_tgt_3 != target_3[ADDR_W-1:2]));
  assign dir_wrong    = is_branch_3 & (prev_taken_3 != taken_3);
  assign flush        = dir_wrong | target_wrong;

  always_comb begin
    if (flush)
      branch_pc = taken_3 ? target_3 : pc_3 + ADDR_W'(4);
    else if (taken)
      branch_pc = {tgt_q[idx_1][way_1], 2'b00};
    else
      branch_pc = pc_1 + ADDR_W'(4);
  end

  assign upd_en  = ~memory_stall & is_branch_3;
  assign cnt_cur = cnt_q[idx_3][way_3];

  always_comb begin
    cnt_d = cnt_cur;
    if (taken_3 && cnt_cur != 2'b11)
      cnt_d = cnt_cur + 2'b01;
    else if (!taken_3 && cnt_cur != 2'b00)
      cnt_d = cnt_cur - 2'b01;
  end

  always_comb begin
    if (!valid_q[idx_3][0])
      victim = 1'b0;
    else if (!valid_q[idx_3][1])
      victim = 1'b1;
    else
      victim = lru_q[idx_3];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= 2'b00;
        cnt_q[s][0] <= 2'b00;
        cnt_q[s][1] <= 2'b00;
      end
      lru_q <= '0;
    end else if (upd_en) begin
      if (hit_3) begin
        if (target_wrong) begin
          tgt_q[idx_3][way_3] <= target_3[ADDR_W-1:2];
          cnt_q[idx_3][way_3] <= CNT_INIT;
        end else begin
          cnt_q[idx_3][way_3] <= cnt_d;
        end
        lru_q[idx_3] <= ~way_3;
      end else if (taken_3) begin
        valid_q[idx_3][victim] <= 1'b1;
        tag_q[idx_3][victim]   <= tag_3;
        tgt_q[idx_3][victim]   <= target_3[ADDR_W-1:2];
        cnt_q[idx_3][victim]   <= CNT_INIT;
        lru_q[idx_3]           <= ~victim;
      end
    end
  end

`ifdef BTB_PERF_EN
  logic [31:0] perf_lookups_q, perf_mispredicts_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lookups_q     <= '0;
      perf_mispredicts_q <= '0;
    end else if (upd_en) begin
      perf_lookups_q <= perf_lookups_q + 32'd1;
      if (flush)
        perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
    end
  end

  assign perf_lookups     = perf_lookups_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule
